acc_cpu_seq: RTL

- Parametrised successor to the single-cycle accumulator processor. Generalises data width, register-file depth, program-counter width and call-stack depth.
- Adds the following over the single-cycle design:
  - an instruction-memory request/acknowledge fetch interface, so program memory may have variable latency;
  - Zero and Carry flags, with conditional jumps on them;
  - a bounded call stack with an error flag;
  - a HALT state.
- Sits at the top of the core. The program ROM/RAM is external, behind the imem handshake.

---
 rtl/acc_cpu_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_seq.sv
// Multi-cycle accumulator CPU with handshaked instruction fetch, Z/C flags and a bounded call stack.
// Optional MUL opcode (0x0A) enabled by defining ACC_CPU_SEQ_MUL_EN.
module acc_cpu_seq #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned REG_NUM     = 16,
  parameter int unsigned PC_W        = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic [PC_W-1:0]       imem_addr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [8+WIDTH-1:0]    imem_data,
  output logic [WIDTH-1:0]      out,
  output logic                  halted,
  output logic                  stack_err
);

  localparam int unsigned IW  = 8 + WIDTH;
  localparam int unsigned RW  = $clog2(REG_NUM);
  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_LD   = 8'h07;
  localparam logic [7:0] OP_ST   = 8'h08;
  localparam logic [7:0] OP_ADDI = 8'h09;
`ifdef ACC_CPU_SEQ_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h0A;
`endif
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_JNZ  = 8'h12;
  localparam logic [7:0] OP_JC   = 8'h13;
  localparam logic [7:0] OP_CALL = 8'h14;
  localparam logic [7:0] OP_RET  = 8'h15;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [WIDTH-1:0]  acc;
  logic              z_flag;
  logic              c_flag;
  logic [7:0]        op;
  logic [WIDTH-1:0]  imm;
  logic [SPW-1:0]    sp;
  logic [WIDTH-1:0]  regs  [REG_NUM];
  logic [PC_W-1:0]   stack [STACK_DEPTH];

  logic [RW-1:0]     r_idx;
  logic [WIDTH-1:0]  rsel;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jmp_tgt;
  logic [SPW-1:0]    sp_m1;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c;
  logic              alu_wr;
  logic              flag_wr;

  assign imem_addr = pc;
  assign r_idx     = imm[RW-1:0];
  assign rsel      = regs[r_idx];
  assign pc_inc    = pc + PC_W'(1);
  assign jmp_tgt   = imm[PC_W-1:0];
  assign sp_m1     = sp - SPW'(1);

`ifdef ACC_CPU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(acc) * (2*WIDTH)'(rsel);
`endif

  // Accumulator result and flag updates for the latched instruction
  always_comb begin
    alu_res = acc;
    alu_c   = c_flag;
    alu_wr  = 1'b0;
    flag_wr = 1'b0;
    case (op)
      OP_LDI:  begin alu_res = imm;  alu_wr = 1'b1; end
      OP_LD:   begin alu_res = rsel; alu_wr = 1'b1; end
      OP_ADD:  begin {alu_c, alu_res} = {1'b0, acc} + {1'b0, rsel}; alu_wr = 1'b1; flag_wr = 1'b1; end
      OP_SUB:  begin {alu_c, alu_res} = {1'b0, acc} - {1'b0, rsel}; alu_wr = 1'b1; flag_wr = 1'b1; end
      OP_ADDI: begin {alu_c, alu_res} = {1'b0, acc} + {1'b0, imm};  alu_wr = 1'b1; flag_wr = 1'b1; end
      OP_AND:  begin alu_res = acc & rsel; alu_c = 1'b0; alu_wr = 1'b1; flag_wr = 1'b1; end
      OP_OR:   begin alu_res = acc | rsel; alu_c = 1'b0; alu_wr = 1'b1; flag_wr = 1'b1; end
      OP_XOR:  begin alu_res = acc ^ rsel; alu_c = 1'b0; alu_wr = 1'b1; flag_wr = 1'b1; end
`ifdef ACC_CPU_SEQ_MUL_EN
      OP_MUL:  begin alu_res = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; alu_wr = 1'b1; flag_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Fetch/execute/halt sequencer; later assignments to state/req override the defaults
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_FETCH;
      pc        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      op        <= '0;
      imm       <= '0;
      sp        <= '0;
      out       <= '0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
      imem_req  <= 1'b0;
      for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            op       <= imem_data[IW-1:WIDTH];
            imm      <= imem_data[WIDTH-1:0];
            imem_req <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          pc       <= pc_inc;
          if (alu_wr) begin
            acc <= alu_res;
            out <= alu_res;
          end
          if (flag_wr) begin
            z_flag <= (alu_res == '0);
            c_flag <= alu_c;
          end
          case (op)
            OP_ST:  regs[r_idx] <= acc;
            OP_JMP: pc <= jmp_tgt;
            OP_JZ:  if (z_flag)  pc <= jmp_tgt;
            OP_JNZ: if (!z_flag) pc <= jmp_tgt;
            OP_JC:  if (c_flag)  pc <= jmp_tgt;
            OP_CALL: begin
              if (sp == SPW'(STACK_DEPTH)) begin
                stack_err <= 1'b1;
                halted    <= 1'b1;
                imem_req  <= 1'b0;
                state     <= S_HALT;
              end else begin
                stack[sp[SPW-2:0]] <= pc_inc;
                sp <= sp + SPW'(1);
                pc <= jmp_tgt;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                stack_err <= 1'b1;
                halted    <= 1'b1;
                imem_req  <= 1'b0;
                state     <= S_HALT;
              end else begin
                sp <= sp_m1;
                pc <= stack[sp_m1[SPW-2:0]];
              end
            end
            OP_HALT: begin
              halted   <= 1'b1;
              imem_req <= 1'b0;
              state    <= S_HALT;
            end
            default: ;
          endcase
        end
        S_HALT: imem_req <= 1'b0;
        default: begin
          state    <= S_FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
